// File: rtl/bpu_pkg.sv
// Shared branch-predictor types: branch type codes, 2-bit counter codes and the
// checkpoint entry recorded for each predicted control-flow instruction.
package bpu_pkg;

  typedef enum logic [1:0] {
    TYPE_NO     = 2'b00,
    TYPE_BRANCH = 2'b01,
    TYPE_RET    = 2'b10,
    TYPE_J      = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic [31:0] addr;
    br_type_e    btype;
    logic        pred;
    logic [31:0] target;
  } pred_entry_t;

endpackage

// File: rtl/bpu_pred_fifo_2w1r.sv
// Prediction checkpoint storage: 2 in-order write ports, 1 read port, synchronous clear; head is
// visible combinationally, writes/pops take effect next edge; no internal backpressure (caller gates writes).
module bpu_pred_fifo_2w1r
  import bpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   we1_i,
  input  pred_entry_t            we1_dat_i,
  input  logic                   we2_i,
  input  pred_entry_t            we2_dat_i,
  input  logic                   re_i,
  output pred_entry_t            head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  pred_entry_t      mem_q [DEPTH];
  pred_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr2_ptr;
  logic [PTR_W-1:0] we1_inc, we2_inc;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    we1_inc = {{(PTR_W-1){1'b0}}, we1_i};
    we2_inc = {{(PTR_W-1){1'b0}}, we2_i};
    // Slot 2 lands right behind slot 1, or at the tail when slot 1 is idle.
    wr2_ptr = wr_q + we1_inc;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (we1_i) mem_d[wr_q[IDX_W-1:0]] = we1_dat_i;
      if (we2_i) mem_d[wr2_ptr[IDX_W-1:0]] = we2_dat_i;
      wr_d = wr_q + we1_inc + we2_inc;
      if (re_i) rd_d = rd_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Extra pointer bit separates full (MSBs differ) from empty (equal).
  assign empty_o = (rd_q == wr_q);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[IDX_W-1:0]];

endmodule

// File: rtl/bpu_pred_check_queue.sv
// In-order prediction check queue: records up to 2 predictions/cycle, checks the head on EX resolve,
// redirect/sync_err 1 cycle after resolve; enq_ready_o low when <2 entries free. Option: BPU_PRED_STATS_EN.
module bpu_pred_check_queue
  import bpu_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] FALLTHRU_OFS = 32'd8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq1_valid_i,
  input  logic [31:0]            enq1_addr_i,
  input  logic [1:0]             enq1_type_i,
  input  logic                   enq1_pred_i,
  input  logic [31:0]            enq1_target_i,
  input  logic                   enq2_valid_i,
  input  logic [31:0]            enq2_addr_i,
  input  logic [1:0]             enq2_type_i,
  input  logic                   enq2_pred_i,
  input  logic [31:0]            enq2_target_i,
  output logic                   enq_ready_o,
  input  logic                   ex_valid_i,
  input  logic [1:0]             ex_branch_type_i,
  input  logic [31:0]            ex_inst_addr_i,
  input  logic                   ex_branch_success_i,
  input  logic [31:0]            ex_target_i,
  input  logic                   flush_i,
  output logic                   mispredict_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   sync_err_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef BPU_PRED_STATS_EN
  ,
  output logic [31:0]            stat_resolved_o,
  output logic [31:0]            stat_mispred_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pred_entry_t      e1, e2, head;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             enq1_do, enq2_do, resolve, head_hit, sync_bad, pred_bad, redirect;
  logic             clr, we1, we2, re;
  logic             unused_head_type;

  logic        mispredict_q, mispredict_d;
  logic        sync_err_q, sync_err_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    e1 = '{addr: enq1_addr_i, btype: br_type_e'(enq1_type_i), pred: enq1_pred_i, target: enq1_target_i};
    e2 = '{addr: enq2_addr_i, btype: br_type_e'(enq2_type_i), pred: enq2_pred_i, target: enq2_target_i};

    enq1_do  = enq_ready_o && enq1_valid_i && (enq1_type_i != TYPE_NO);
    enq2_do  = enq_ready_o && enq2_valid_i && (enq2_type_i != TYPE_NO);
    resolve  = ex_valid_i && (ex_branch_type_i != TYPE_NO);
    head_hit = !empty && (head.addr == ex_inst_addr_i);
    sync_bad = resolve && !head_hit;
    pred_bad = resolve && head_hit &&
               ((head.pred != ex_branch_success_i) ||
                (head.pred && ex_branch_success_i && (head.target != ex_target_i)));
    redirect = (sync_bad || pred_bad) && !flush_i;

    // Any redirect discards younger records, including this cycle's wrong-path enqueues.
    clr = flush_i || redirect;
    we1 = enq1_do && !clr;
    we2 = enq2_do && !clr;
    re  = resolve && !empty && !clr;

    mispredict_d  = redirect;
    sync_err_d    = sync_bad && !flush_i;
    redirect_pc_d = redirect_pc_q;
    if (redirect) begin
      redirect_pc_d = ex_branch_success_i ? ex_target_i : ex_inst_addr_i + FALLTHRU_OFS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mispredict_q  <= mispredict_d;
      sync_err_q    <= sync_err_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  bpu_pred_fifo_2w1r #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .we1_i     (we1),
    .we1_dat_i (e1),
    .we2_i     (we2),
    .we2_dat_i (e2),
    .re_i      (re),
    .head_o    (head),
    .empty_o   (empty),
    .count_o   (count)
  );

  assign unused_head_type = ^head.btype;
  assign enq_ready_o      = (count <= CNT_W'(DEPTH - 2));
  assign count_o          = count;
  assign mispredict_o     = mispredict_q;
  assign sync_err_o       = sync_err_q;
  assign redirect_pc_o    = redirect_pc_q;

`ifdef BPU_PRED_STATS_EN
  logic [31:0] stat_res_q, stat_res_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  // Saturating; a flush cancels the resolve so it is not counted.
  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (resolve && !flush_i && (stat_res_q != '1)) stat_res_d = stat_res_q + 32'd1;
    if (redirect && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved_o = stat_res_q;
  assign stat_mispred_o  = stat_mis_q;
`endif

endmodule

// File: tb/tb_bpu_pred_check_queue.sv
// Directed bench for bpu_pred_check_queue (DEPTH=8, FALLTHRU_OFS=8); stats ports checked when
// BPU_PRED_STATS_EN is defined.
module tb_bpu_pred_check_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq1_valid_i, enq1_pred_i, enq2_valid_i, enq2_pred_i;
  logic [31:0] enq1_addr_i, enq1_target_i, enq2_addr_i, enq2_target_i;
  logic [1:0]  enq1_type_i, enq2_type_i, ex_branch_type_i;
  logic        enq_ready_o, ex_valid_i, ex_branch_success_i, flush_i;
  logic [31:0] ex_inst_addr_i, ex_target_i, redirect_pc_o;
  logic        mispredict_o, sync_err_o;
  logic [3:0]  count_o;
`ifdef BPU_PRED_STATS_EN
  logic [31:0] stat_resolved_o, stat_mispred_o;
`endif

  int errors = 0;
  int checks = 0;
  int exp_res = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  bpu_pred_check_queue dut (
    .clk                 (clk),
    .rst                 (rst),
    .enq1_valid_i        (enq1_valid_i),
    .enq1_addr_i         (enq1_addr_i),
    .enq1_type_i         (enq1_type_i),
    .enq1_pred_i         (enq1_pred_i),
    .enq1_target_i       (enq1_target_i),
    .enq2_valid_i        (enq2_valid_i),
    .enq2_addr_i         (enq2_addr_i),
    .enq2_type_i         (enq2_type_i),
    .enq2_pred_i         (enq2_pred_i),
    .enq2_target_i       (enq2_target_i),
    .enq_ready_o         (enq_ready_o),
    .ex_valid_i          (ex_valid_i),
    .ex_branch_type_i    (ex_branch_type_i),
    .ex_inst_addr_i      (ex_inst_addr_i),
    .ex_branch_success_i (ex_branch_success_i),
    .ex_target_i         (ex_target_i),
    .flush_i             (flush_i),
    .mispredict_o        (mispredict_o),
    .redirect_pc_o       (redirect_pc_o),
    .sync_err_o          (sync_err_o),
    .count_o             (count_o)
`ifdef BPU_PRED_STATS_EN
    ,
    .stat_resolved_o     (stat_resolved_o),
    .stat_mispred_o      (stat_mispred_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq1_valid_i = 0; enq1_addr_i = 0; enq1_type_i = 0; enq1_pred_i = 0; enq1_target_i = 0;
    enq2_valid_i = 0; enq2_addr_i = 0; enq2_type_i = 0; enq2_pred_i = 0; enq2_target_i = 0;
    ex_valid_i = 0; ex_branch_type_i = 0; ex_inst_addr_i = 0; ex_branch_success_i = 0; ex_target_i = 0;
    flush_i = 0;
  endtask

  task automatic set_enq1(input logic [31:0] a, input logic [1:0] t, input logic p, input logic [31:0] tg);
    enq1_valid_i = 1; enq1_addr_i = a; enq1_type_i = t; enq1_pred_i = p; enq1_target_i = tg;
  endtask

  task automatic set_enq2(input logic [31:0] a, input logic [1:0] t, input logic p, input logic [31:0] tg);
    enq2_valid_i = 1; enq2_addr_i = a; enq2_type_i = t; enq2_pred_i = p; enq2_target_i = tg;
  endtask

  task automatic set_ex(input logic [1:0] t, input logic [31:0] a, input logic s, input logic [31:0] tg);
    ex_valid_i = 1; ex_branch_type_i = t; ex_inst_addr_i = a; ex_branch_success_i = s; ex_target_i = tg;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({count_o, mispredict_o, sync_err_o, enq_ready_o} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d mis=%b serr=%b rdy=%b exp cnt=0 mis=0 serr=0 rdy=1",
               count_o, mispredict_o, sync_err_o, enq_ready_o);
    end
    checks++;
    if (redirect_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_redirect got=%h exp=00000000", redirect_pc_o);
    end
    rst = 0;
  endtask

  task automatic test_match();
    set_enq1(32'h100, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    checks++;
    if (count_o !== 4'd1) begin
      errors++;
      $display("FAIL match_count_after_enq got=%0d exp=1", count_o);
    end
    set_ex(2'b01, 32'h100, 1'b0, 32'h104);
    tick(); idle();
    exp_res++;
    checks++;
    if ({mispredict_o, sync_err_o, count_o} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL match_pop got mis=%b serr=%b cnt=%0d exp mis=0 serr=0 cnt=0",
               mispredict_o, sync_err_o, count_o);
    end
  endtask

  task automatic test_mispredict_taken();
    set_enq1(32'h200, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    // Mismatch alongside a wrong-path enqueue that must be discarded.
    set_ex(2'b01, 32'h200, 1'b1, 32'h300);
    set_enq1(32'h208, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    exp_res++; exp_mis++;
    checks++;
    if ({mispredict_o, sync_err_o, count_o} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL taken_mispredict got mis=%b serr=%b cnt=%0d exp mis=1 serr=0 cnt=0",
               mispredict_o, sync_err_o, count_o);
    end
    checks++;
    if (redirect_pc_o !== 32'h300) begin
      errors++;
      $display("FAIL taken_redirect got=%h exp=00000300", redirect_pc_o);
    end
    tick();
    checks++;
    if (mispredict_o !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_pulse_end got=%b exp=0", mispredict_o);
    end
  endtask

  task automatic test_redirect_table();
    logic [31:0] v_addr [4] = '{32'h400, 32'h440, 32'hFFFF_FFFC, 32'h880};
    logic [1:0]  v_type [4] = '{2'b01, 2'b01, 2'b01, 2'b11};
    logic        v_pred [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] v_ptgt [4] = '{32'h500, 32'h500, 32'h10, 32'h800};
    logic        v_succ [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] v_atgt [4] = '{32'h0, 32'h580, 32'h0, 32'h800};
    logic        v_mis  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] v_rpc  [4] = '{32'h408, 32'h580, 32'h4, 32'h0};
    for (int i = 0; i < 4; i++) begin
      set_enq1(v_addr[i], v_type[i], v_pred[i], v_ptgt[i]);
      tick(); idle();
      set_ex(v_type[i], v_addr[i], v_succ[i], v_atgt[i]);
      tick(); idle();
      exp_res++;
      if (v_mis[i]) exp_mis++;
      checks++;
      if ({mispredict_o, sync_err_o, count_o} !== {v_mis[i], 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL redirect_vec%0d got mis=%b serr=%b cnt=%0d exp mis=%b serr=0 cnt=0",
                 i, mispredict_o, sync_err_o, count_o, v_mis[i]);
      end
      if (v_mis[i]) begin
        checks++;
        if (redirect_pc_o !== v_rpc[i]) begin
          errors++;
          $display("FAIL redirect_pc_vec%0d got=%h exp=%h", i, redirect_pc_o, v_rpc[i]);
        end
      end
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] q[$];
    logic [31:0] nxt;
    logic [31:0] h;
    nxt = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      set_enq1(nxt, 2'b01, 1'b0, 32'h0);
      set_enq2(nxt + 32'h4, 2'b01, 1'b0, 32'h0);
      q.push_back(nxt); q.push_back(nxt + 32'h4);
      nxt = nxt + 32'h8;
      tick(); idle();
    end
    checks++;
    if ({count_o, enq_ready_o} !== {4'd6, 1'b1}) begin
      errors++;
      $display("FAIL fill_six got cnt=%0d rdy=%b exp cnt=6 rdy=1", count_o, enq_ready_o);
    end
    set_enq1(nxt, 2'b01, 1'b0, 32'h0);
    q.push_back(nxt); nxt = nxt + 32'h4;
    tick(); idle();
    checks++;
    if ({count_o, enq_ready_o} !== {4'd7, 1'b0}) begin
      errors++;
      $display("FAIL fill_seven got cnt=%0d rdy=%b exp cnt=7 rdy=0", count_o, enq_ready_o);
    end
    set_enq1(32'hDEAD0000, 2'b01, 1'b0, 32'h0);
    set_enq2(32'hDEAD0004, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    checks++;
    if (count_o !== 4'd7) begin
      errors++;
      $display("FAIL dropped_enq got cnt=%0d exp cnt=7", count_o);
    end
    h = q.pop_front();
    set_ex(2'b01, h, 1'b0, 32'h0);
    tick(); idle();
    exp_res++;
    checks++;
    if ({count_o, enq_ready_o, mispredict_o, sync_err_o} !== {4'd6, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pop_reopens got cnt=%0d rdy=%b mis=%b serr=%b exp cnt=6 rdy=1 mis=0 serr=0",
               count_o, enq_ready_o, mispredict_o, sync_err_o);
    end
    // Enqueue and pop together until both pointers have wrapped twice.
    for (int i = 0; i < 30; i++) begin
      h = q.pop_front();
      set_ex(2'b01, h, 1'b0, 32'h0);
      set_enq1(nxt, 2'b01, 1'b0, 32'h0);
      q.push_back(nxt); nxt = nxt + 32'h4;
      tick(); idle();
      exp_res++;
      checks++;
      if ({mispredict_o, sync_err_o, count_o} !== {1'b0, 1'b0, 4'd6}) begin
        errors++;
        $display("FAIL wrap_step%0d got mis=%b serr=%b cnt=%0d exp mis=0 serr=0 cnt=6",
                 i, mispredict_o, sync_err_o, count_o);
      end
    end
    for (int i = 0; i < 6; i++) begin
      h = q.pop_front();
      set_ex(2'b01, h, 1'b0, 32'h0);
      tick(); idle();
      exp_res++;
      checks++;
      if ({mispredict_o, sync_err_o, count_o} !== {1'b0, 1'b0, 4'(5 - i)}) begin
        errors++;
        $display("FAIL drain_step%0d got mis=%b serr=%b cnt=%0d exp mis=0 serr=0 cnt=%0d",
                 i, mispredict_o, sync_err_o, count_o, 5 - i);
      end
    end
  endtask

  task automatic test_enq2_only();
    set_enq1(32'hBAD, 2'b00, 1'b1, 32'h0);
    set_enq2(32'hA00, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    checks++;
    if (count_o !== 4'd1) begin
      errors++;
      $display("FAIL enq2_only_count got=%0d exp=1", count_o);
    end
    set_ex(2'b01, 32'hA00, 1'b0, 32'h0);
    tick(); idle();
    exp_res++;
    checks++;
    if ({mispredict_o, sync_err_o, count_o} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL enq2_only_pop got mis=%b serr=%b cnt=%0d exp mis=0 serr=0 cnt=0",
               mispredict_o, sync_err_o, count_o);
    end
  endtask

  task automatic test_sync_err();
    set_enq1(32'h600, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    set_ex(2'b01, 32'h700, 1'b0, 32'h0);
    tick(); idle();
    exp_res++; exp_mis++;
    checks++;
    if ({mispredict_o, sync_err_o, count_o, redirect_pc_o} !== {1'b1, 1'b1, 4'd0, 32'h708}) begin
      errors++;
      $display("FAIL sync_addr got mis=%b serr=%b cnt=%0d pc=%h exp mis=1 serr=1 cnt=0 pc=00000708",
               mispredict_o, sync_err_o, count_o, redirect_pc_o);
    end
    tick();
    checks++;
    if ({mispredict_o, sync_err_o} !== 2'b00) begin
      errors++;
      $display("FAIL sync_pulse_end got mis=%b serr=%b exp 0 0", mispredict_o, sync_err_o);
    end
    set_ex(2'b10, 32'h800, 1'b1, 32'h900);
    tick(); idle();
    exp_res++; exp_mis++;
    checks++;
    if ({mispredict_o, sync_err_o, count_o, redirect_pc_o} !== {1'b1, 1'b1, 4'd0, 32'h900}) begin
      errors++;
      $display("FAIL sync_empty got mis=%b serr=%b cnt=%0d pc=%h exp mis=1 serr=1 cnt=0 pc=00000900",
               mispredict_o, sync_err_o, count_o, redirect_pc_o);
    end
  endtask

  task automatic test_flush();
    set_enq1(32'h900, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    flush_i = 1;
    set_ex(2'b01, 32'h900, 1'b1, 32'hA00);
    set_enq1(32'h910, 2'b01, 1'b0, 32'h0);
    set_enq2(32'h920, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    checks++;
    if ({mispredict_o, sync_err_o, count_o} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL flush got mis=%b serr=%b cnt=%0d exp mis=0 serr=0 cnt=0",
               mispredict_o, sync_err_o, count_o);
    end
    checks++;
    if (redirect_pc_o !== 32'h900) begin
      errors++;
      $display("FAIL flush_redirect_hold got=%h exp=00000900", redirect_pc_o);
    end
`ifdef BPU_PRED_STATS_EN
    checks++;
    if ({stat_resolved_o, stat_mispred_o} !== {32'(exp_res), 32'(exp_mis)}) begin
      errors++;
      $display("FAIL flush_stats got res=%0d mis=%0d exp res=%0d mis=%0d",
               stat_resolved_o, stat_mispred_o, exp_res, exp_mis);
    end
`endif
  endtask

  task automatic test_mid_reset();
    set_enq1(32'hC00, 2'b01, 1'b0, 32'h0);
    set_enq2(32'hC04, 2'b01, 1'b0, 32'h0);
    tick(); idle();
    rst = 1;
    set_ex(2'b01, 32'hC00, 1'b1, 32'hD00);
    tick(); idle();
    rst = 0;
    exp_res = 0; exp_mis = 0;
    checks++;
    if ({mispredict_o, sync_err_o, count_o, enq_ready_o, redirect_pc_o} !==
        {1'b0, 1'b0, 4'd0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset got mis=%b serr=%b cnt=%0d rdy=%b pc=%h exp 0 0 0 1 00000000",
               mispredict_o, sync_err_o, count_o, enq_ready_o, redirect_pc_o);
    end
`ifdef BPU_PRED_STATS_EN
    checks++;
    if ({stat_resolved_o, stat_mispred_o} !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset_stats got res=%0d mis=%0d exp 0 0", stat_resolved_o, stat_mispred_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_match();
    test_mispredict_taken();
    test_redirect_table();
    test_full_wrap();
    test_enq2_only();
    test_sync_err();
    test_flush();
    $display("resolves driven before mid reset model clear: res=%0d mis=%0d", exp_res, exp_mis);
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
